// File: rtl/step_pulse_gen_if.sv
// Handshake bundle between the clock-divider side, the core and step_pulse_gen.
// The master drives the slow clock, button, mode switch and halt; the slave returns tick status.
interface step_pulse_gen_if;
    logic       slow_clk;
    logic       step_btn;
    logic       run_mode;
    logic       halt;
    logic       tick;
    logic [7:0] tick_count;
    logic [1:0] state;

    modport master (
        output slow_clk, step_btn, run_mode, halt,
        input  tick, tick_count, state
    );

    modport slave (
        input  slow_clk, step_btn, run_mode, halt,
        output tick, tick_count, state
    );
endinterface

// File: rtl/step_pulse_gen.sv
// Re-times the divided slow clock into clkin and emits one-cycle tick enables,
// with debounced manual single-step and a sticky halt state.
module step_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic            clkin,
    input  logic            reset,
    step_pulse_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             slow_p0, slow_p1, slow_p2;
    logic             run_p0, run_p1;
    logic             btn_p0, btn_p1;
    logic             btn_deb, btn_deb_q;
    logic [CNT_W-1:0] deb_cnt;
    state_t           st;
    logic             tick_r;
    logic [7:0]       count_r;

    logic slow_rise;
    logic step_press;

    // Stage 0-2: synchronisers; the third slow_clk flop only serves edge detection
    always_ff @(posedge clkin) begin
        if (reset) begin
            slow_p0 <= 1'b0;
            slow_p1 <= 1'b0;
            slow_p2 <= 1'b0;
            run_p0  <= 1'b0;
            run_p1  <= 1'b0;
            btn_p0  <= 1'b0;
            btn_p1  <= 1'b0;
        end else begin
            slow_p0 <= bus.slow_clk;
            slow_p1 <= slow_p0;
            slow_p2 <= slow_p1;
            run_p0  <= bus.run_mode;
            run_p1  <= run_p0;
            btn_p0  <= bus.step_btn;
            btn_p1  <= btn_p0;
        end
    end

    assign slow_rise  = slow_p1 & ~slow_p2;
    assign step_press = btn_deb & ~btn_deb_q;

    // Debouncer: a new level must persist DEBOUNCE_CYCLES cycles without a gap
    always_ff @(posedge clkin) begin
        if (reset) begin
            btn_deb   <= 1'b0;
            btn_deb_q <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            btn_deb_q <= btn_deb;
            if (btn_p1 != btn_deb) begin
                if (deb_cnt == DEB_LAST) begin
                    btn_deb <= btn_p1;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Control FSM: tick is decided from the current state, so a mode change lands one cycle later
    always_ff @(posedge clkin) begin
        if (reset) begin
            st      <= IDLE;
            tick_r  <= 1'b0;
            count_r <= 8'd0;
        end else begin
            if (tick_r)
                count_r <= count_r + 8'd1;
            case (st)
                IDLE: begin
                    tick_r <= step_press & ~bus.halt;
                    if (bus.halt)
                        st <= HALTED;
                    else if (run_p1)
                        st <= RUN;
                end
                RUN: begin
                    tick_r <= slow_rise & ~bus.halt;
                    if (bus.halt)
                        st <= HALTED;
                    else if (!run_p1)
                        st <= IDLE;
                end
                default: begin
                    tick_r <= 1'b0;
                    st     <= HALTED;
                end
            endcase
        end
    end

    assign bus.tick       = tick_r;
    assign bus.tick_count = count_r;
    assign bus.state      = st;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen: every expected tick cycle is queued when the
// stimulus is driven and popped when the DUT raises tick.
module tb_step_pulse_gen;

    localparam int D = 4;

    logic clkin = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_q[$];
    int   exp_e;
    int   saved;

    step_pulse_gen_if bus();

    step_pulse_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: each observed tick must match the oldest queued expectation
    always @(negedge clkin) begin
        if (!reset && bus.tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tick", cyc, -1);
            end else begin
                exp_e = exp_q.pop_front();
                check("tick_cycle", cyc, exp_e);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        @(negedge clkin);
        check("rst_tick", int'(bus.tick), 0);
        check("rst_count", int'(bus.tick_count), 0);
        check("rst_state", int'(bus.state), 0);
        reset = 1'b0;
    endtask

    task automatic slow_pulse(input int hi, input int lo, input bit expect_tick);
        bus.slow_clk = 1'b1;
        if (expect_tick) exp_q.push_back(cyc + 3);
        wait_cyc(hi);
        bus.slow_clk = 1'b0;
        wait_cyc(lo);
    endtask

    task automatic press(input int hold, input bit expect_tick);
        bus.step_btn = 1'b1;
        if (expect_tick) exp_q.push_back(cyc + 3 + D);
        wait_cyc(hold);
        bus.step_btn = 1'b0;
        wait_cyc(D + 5);
    endtask

    initial begin
        bus.slow_clk = 1'b0;
        bus.step_btn = 1'b0;
        bus.run_mode = 1'b0;
        bus.halt     = 1'b0;
        wait_cyc(3);
        do_reset();
        wait_cyc(2);

        // Free-run on slow_clk
        bus.run_mode = 1'b1;
        wait_cyc(2);
        check("run_entry_idle", int'(bus.state), 0);
        wait_cyc(2);
        check("run_entry_run", int'(bus.state), 1);
        for (int k = 1; k <= 3; k++) begin
            slow_pulse(10, 10, 1'b1);
            check("run_count", int'(bus.tick_count), k);
        end
        wait_cyc(5);
        check("const_slow_count", int'(bus.tick_count), 3);

        // Debounced single step in IDLE
        bus.run_mode = 1'b0;
        do_reset();
        wait_cyc(5);
        check("step_idle_state", int'(bus.state), 0);
        for (int k = 0; k < 4; k++) begin
            bus.step_btn = ~k[0];
            wait_cyc(1);
        end
        press(10, 1'b1);
        check("step_count1", int'(bus.tick_count), 1);
        press(10, 1'b1);
        check("step_count2", int'(bus.tick_count), 2);

        // Halt coincident with slow_rise
        bus.run_mode = 1'b1;
        wait_cyc(5);
        check("halt_pre_state", int'(bus.state), 1);
        saved = int'(bus.tick_count);
        bus.slow_clk = 1'b1;
        wait_cyc(2);
        bus.halt = 1'b1;
        wait_cyc(1);
        bus.halt = 1'b0;
        wait_cyc(8);
        bus.slow_clk = 1'b0;
        wait_cyc(4);
        check("halt_state", int'(bus.state), 2);
        slow_pulse(5, 5, 1'b0);
        bus.run_mode = 1'b0;
        press(10, 1'b0);
        bus.run_mode = 1'b1;
        slow_pulse(5, 5, 1'b0);
        check("halt_sticky", int'(bus.state), 2);
        check("halt_count", int'(bus.tick_count), saved);
        do_reset();

        // Counter wrap
        wait_cyc(5);
        for (int k = 1; k <= 257; k++) begin
            slow_pulse(3, 3, 1'b1);
            if (k == 255) check("wrap_255", int'(bus.tick_count), 255);
            if (k == 256) check("wrap_256", int'(bus.tick_count), 0);
            if (k == 257) check("wrap_257", int'(bus.tick_count), 1);
        end

        // Reset mid-debounce: held button must restart the full debounce
        bus.run_mode = 1'b0;
        do_reset();
        wait_cyc(5);
        bus.step_btn = 1'b1;
        wait_cyc(4);
        do_reset();
        exp_q.push_back(cyc + 3 + D);
        wait_cyc(12);
        bus.step_btn = 1'b0;
        wait_cyc(D + 5);
        check("rst_deb_count", int'(bus.tick_count), 1);

        // Reset mid-run with a slow_rise in flight
        bus.run_mode = 1'b1;
        wait_cyc(5);
        slow_pulse(4, 4, 1'b1);
        bus.slow_clk = 1'b1;
        wait_cyc(2);
        bus.slow_clk = 1'b0;
        do_reset();
        wait_cyc(6);
        check("rst_run_none", int'(bus.tick_count), 0);
        check("rst_run_state", int'(bus.state), 1);
        slow_pulse(4, 4, 1'b1);
        check("rst_run_count", int'(bus.tick_count), 1);

        // Step presses during RUN are ignored
        bus.step_btn = 1'b1;
        slow_pulse(3, 3, 1'b1);
        slow_pulse(3, 3, 1'b1);
        bus.step_btn = 1'b0;
        wait_cyc(D + 5);
        check("run_press_count", int'(bus.tick_count), 3);
        bus.run_mode = 1'b0;
        wait_cyc(5);
        check("back_idle_state", int'(bus.state), 0);
        press(10, 1'b1);
        check("back_idle_count", int'(bus.tick_count), 4);

        wait_cyc(10);
        check("pending_ticks", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
